// File: rtl/fmap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmap_pkg
// Description : Shared frame geometry defaults, collector FSM states and
//               width helpers for the pixel stream blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fmap_pkg;

    localparam int DEF_I_F_BW = 8;
    localparam int DEF_IX     = 28;
    localparam int DEF_IY     = 28;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    function automatic int addr_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // One extra bit beyond pixel+address width keeps a full-frame sum exact.
    function automatic int sum_width(input int bw, input int total);
        return bw + addr_width(total) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : fmap_frame_ram
// Description : Simple dual-port frame buffer, read-first, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_frame_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    // Same-edge write lands after this read samples, giving read-first data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rd_data <= '0;
        else if (i_rd_en)
            r_rd_data <= ({1'b0, i_rd_addr} < c_depth) ? r_mem[i_rd_addr] : '0;
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fmap_collector.sv
`default_nettype none
// ============================================================================
// Module      : fmap_collector
// Description : Captures a raster pixel stream into a frame buffer, tracks
//               count/sum and sticky error flags, with debug readback port.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_collector
    import fmap_pkg::*;
#(
    parameter int I_F_BW       = DEF_I_F_BW,
    parameter int IX           = DEF_IX,
    parameter int IY           = DEF_IY,
    parameter int TOTAL_PIXELS = IX * IY,
    parameter int MAX_GAP      = 16,
    localparam int AW          = addr_width(TOTAL_PIXELS),
    localparam int SW          = sum_width(I_F_BW, TOTAL_PIXELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [I_F_BW-1:0] i_pixel,
    input  logic              i_clear,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [I_F_BW-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [AW:0]       o_count,
    output logic [SW-1:0]     o_sum,
    output logic              o_err_ovf,
    output logic              o_err_gap
);

    localparam int            GW         = $clog2(MAX_GAP + 1);
    localparam logic [AW:0]   c_total    = (AW+1)'(TOTAL_PIXELS);
    localparam logic [GW-1:0] c_gap_last = GW'(MAX_GAP - 1);

    state_t        r_state, w_state_nxt;
    logic [AW:0]   r_count, w_count_nxt, w_count_inc;
    logic [SW-1:0] r_sum, w_sum_nxt;
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic          r_err_ovf, w_err_ovf_nxt;
    logic          r_err_gap, w_err_gap_nxt;
    logic          r_rd_valid;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;

    assign w_count_inc = r_count + (AW+1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_sum      <= '0;
            r_gap      <= '0;
            r_err_ovf  <= 1'b0;
            r_err_gap  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_sum      <= w_sum_nxt;
            r_gap      <= w_gap_nxt;
            r_err_ovf  <= w_err_ovf_nxt;
            r_err_gap  <= w_err_gap_nxt;
            r_rd_valid <= i_rd_en;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_sum_nxt     = r_sum;
        w_gap_nxt     = r_gap;
        w_err_ovf_nxt = r_err_ovf;
        w_err_gap_nxt = r_err_gap;
        w_wr_en       = 1'b0;
        w_wr_addr     = (r_state == S_IDLE) ? '0 : r_count[AW-1:0];
        if (i_clear) begin
            // Rearm drops any same-cycle pixel; buffer contents are kept.
            w_state_nxt   = S_IDLE;
            w_count_nxt   = '0;
            w_sum_nxt     = '0;
            w_gap_nxt     = '0;
            w_err_ovf_nxt = 1'b0;
            w_err_gap_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        w_wr_en     = 1'b1;
                        w_count_nxt = (AW+1)'(1);
                        w_sum_nxt   = SW'(i_pixel);
                        w_gap_nxt   = '0;
                        w_state_nxt = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (i_valid) begin
                        w_wr_en     = 1'b1;
                        w_count_nxt = w_count_inc;
                        w_sum_nxt   = r_sum + SW'(i_pixel);
                        w_gap_nxt   = '0;
                        if (w_count_inc == c_total)
                            w_state_nxt = S_FULL;
                    end else if (r_gap == c_gap_last) begin
                        w_err_gap_nxt = 1'b1;
                        w_gap_nxt     = '0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_gap_nxt = r_gap + GW'(1);
                    end
                end
                S_FULL: begin
                    if (i_valid)
                        w_err_ovf_nxt = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    fmap_frame_ram #(
        .DW    (I_F_BW),
        .DEPTH (TOTAL_PIXELS),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_pixel),
        .i_rd_en   (i_rd_en),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    assign o_rd_valid = r_rd_valid;
    assign o_busy     = (r_state == S_CAPTURE);
    assign o_done     = (r_state == S_FULL);
    assign o_count    = r_count;
    assign o_sum      = r_sum;
    assign o_err_ovf  = r_err_ovf;
    assign o_err_gap  = r_err_gap;

endmodule
`default_nettype wire

// File: tb/tb_fmap_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmap_collector
// Description : Directed self-checking bench for fmap_collector with a
//               readback scoreboard and a pixel/count/sum reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmap_collector;

    localparam int TOTAL = 784;
    localparam int AW    = 10;
    localparam int SW    = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [7:0]    i_pixel;
    logic          i_clear;
    logic          i_rd_en;
    logic [AW-1:0] i_rd_addr;
    logic [7:0]    o_rd_data;
    logic          o_rd_valid;
    logic          o_busy;
    logic          o_done;
    logic [AW:0]   o_count;
    logic [SW-1:0] o_sum;
    logic          o_err_ovf;
    logic          o_err_gap;

    int n_checks = 0;
    int n_errors = 0;

    int m_mem [TOTAL];
    int m_count;
    int m_sum;
    int exp_q[$];

    fmap_collector dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_pixel    (i_pixel),
        .i_clear    (i_clear),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_count    (o_count),
        .o_sum      (o_sum),
        .o_err_ovf  (o_err_ovf),
        .o_err_gap  (o_err_gap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int busy, input int done,
                             input int cnt, input int sum, input int ovf, input int gap);
        check({tag, "_busy"},  32'(o_busy),    32'(busy));
        check({tag, "_done"},  32'(o_done),    32'(done));
        check({tag, "_count"}, 32'(o_count),   32'(cnt));
        check({tag, "_sum"},   32'(o_sum),     32'(sum));
        check({tag, "_ovf"},   32'(o_err_ovf), 32'(ovf));
        check({tag, "_gap"},   32'(o_err_gap), 32'(gap));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted pixel and mirrors it into the reference model.
    task automatic push_pix(input int p);
        i_valid = 1'b1;
        i_pixel = p[7:0];
        tick();
        i_valid = 1'b0;
        m_mem[m_count] = p & 255;
        m_count++;
        m_sum += p & 255;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input int addr);
        i_rd_en   = 1'b1;
        i_rd_addr = addr[AW-1:0];
        exp_q.push_back((addr < TOTAL) ? m_mem[addr] : 0);
        tick();
        i_rd_en = 1'b0;
    endtask

    // Readback scoreboard: every qualified read pops one expected value.
    always @(negedge clk) begin
        if (!reset && o_rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(o_rd_valid), 32'd0);
            end else begin
                check("rd_data", 32'(o_rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_pixel = '0; i_clear = 1'b0;
        i_rd_en = 1'b0; i_rd_addr = '0;
        m_count = 0; m_sum = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        idle(3);
        check_all("reset", 0, 0, 0, 0, 0, 0);
        check("reset_rd_valid", 32'(o_rd_valid), 32'd0);
        reset = 1'b0;
        idle(2);
        check_all("post_reset", 0, 0, 0, 0, 0, 0);

        // Back-to-back frame, value = address[7:0]
        for (int i = 0; i < TOTAL - 1; i++) push_pix(i);
        check_all("t1_penult", 1, 0, m_count, m_sum, 0, 0);
        push_pix(TOTAL - 1);
        check_all("t1_full", 0, 1, TOTAL, m_sum, 0, 0);
        rd(300);
        rd(0);
        rd(783);
        rd(800);
        rd(1023);
        idle(2);

        // Overflow in FULL leaves buffer, count and sum untouched
        i_valid = 1'b1; i_pixel = 8'hFF;
        idle(5);
        i_valid = 1'b0;
        check_all("t4_ovf", 0, 1, TOTAL, m_sum, 1, 0);
        rd(0);
        rd(783);
        idle(2);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        m_count = 0; m_sum = 0;
        check_all("t4_clear", 0, 0, 0, 0, 0, 0);

        // Frame with 3 idle cycles between pixels
        for (int i = 0; i < TOTAL; i++) begin
            push_pix(i * 7 + 3);
            if (i != TOTAL - 1) idle(3);
        end
        check_all("t2_full", 0, 1, TOTAL, m_sum, 0, 0);
        rd(1);
        rd(500);
        idle(2);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        m_count = 0; m_sum = 0;

        // Gap timeout after 100 pixels
        for (int i = 0; i < 100; i++) push_pix(i + 50);
        idle(15);
        check_all("t3_gap15", 1, 0, 100, m_sum, 0, 0);
        idle(1);
        check_all("t3_abort", 0, 0, 100, m_sum, 0, 1);
        idle(3);
        check_all("t3_hold", 0, 0, 100, m_sum, 0, 1);
        m_count = 0; m_sum = 0;
        push_pix(8'h21);
        check_all("t3_restart", 1, 0, 1, m_sum, 0, 1);
        for (int i = 0; i < 4; i++) push_pix(i + 200);

        // Clear beats a same-cycle valid
        i_clear = 1'b1; i_valid = 1'b1; i_pixel = 8'h77;
        tick();
        i_clear = 1'b0; i_valid = 1'b0;
        m_count = 0; m_sum = 0;
        check_all("t5_clear", 0, 0, 0, 0, 0, 0);
        idle(2);
        check_all("t5_idle", 0, 0, 0, 0, 0, 0);
        rd(5);
        rd(4);
        idle(2);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 400; i++) push_pix(i + 100);
        #2 reset = 1'b1;
        #1 check_all("t6_async", 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        m_count = 0; m_sum = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (i == 10) begin
                // Read-first: same-address read during the write sees old data
                i_rd_en   = 1'b1;
                i_rd_addr = 10'd10;
                exp_q.push_back(m_mem[10]);
            end
            push_pix(i * 3 + 1);
            i_rd_en = 1'b0;
        end
        check_all("t6_full", 0, 1, TOTAL, m_sum, 0, 0);
        rd(10);
        rd(399);
        rd(783);
        rd(784);
        idle(3);
        check("rd_pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
